// File: rtl/mux_serializer_8b.sv
`default_nettype none
// ============================================================================
// Module      : mux_serializer_8b
// Description : Parallel-in, serial-out stage. An 8-bit word is taken over a
//               valid/ready handshake, held in a register, and presented one
//               bit per transfer through an 8:1 mux steered by a 3-bit select
//               counter. Supports back-to-back words with no idle cycles.
//               Optional feature macro: MUX_SERIALIZER_PARITY_EN appends one
//               even-parity bit after the eight data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_serializer_8b #(
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       ser_ready,
    output logic       ser_valid,
    output logic       ser_out,
    output logic       ser_last,
    output logic [2:0] sel,
    output logic       busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
`ifdef MUX_SERIALIZER_PARITY_EN
    localparam logic [1:0] c_PARITY = 2'd2;
`endif

    // Select walks start -> end; it only ever returns to start via a reload.
    localparam logic [2:0] c_SEL_START = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [2:0] c_SEL_END   = LSB_FIRST ? 3'd7 : 3'd0;

    logic [1:0] r_state;
    logic [7:0] r_word;
    logic [2:0] r_sel;
    logic       r_valid;
    logic       r_last;

    logic [2:0] w_sel_step;
    logic       w_sel_at_end;
    logic       w_mux_bit;
    logic       w_bit;
    logic       w_accept;
`ifndef MUX_SERIALIZER_PARITY_EN
    logic       w_step_at_end;
`endif

    // The shared 8:1 mux datapath element.
    function automatic logic mux8(input logic [7:0] d, input logic [2:0] s);
        logic r;
        case (s)
            3'd0:    r = d[0];
            3'd1:    r = d[1];
            3'd2:    r = d[2];
            3'd3:    r = d[3];
            3'd4:    r = d[4];
            3'd5:    r = d[5];
            3'd6:    r = d[6];
            default: r = d[7];
        endcase
        return r;
    endfunction

    assign w_sel_step   = LSB_FIRST ? (r_sel + 3'd1) : (r_sel - 3'd1);
    assign w_sel_at_end = (r_sel == c_SEL_END);
`ifndef MUX_SERIALIZER_PARITY_EN
    assign w_step_at_end = (w_sel_step == c_SEL_END);
`endif

    assign w_mux_bit = mux8(r_word, r_sel);
`ifdef MUX_SERIALIZER_PARITY_EN
    assign w_bit = (r_state == c_PARITY) ? (^r_word) : w_mux_bit;
`else
    assign w_bit = w_mux_bit;
`endif

    // Ready when empty, or in the final-bit slot when that bit is leaving now,
    // so the next word loads with zero bubble.
    assign in_ready = ~r_valid | (r_last & ser_ready);
    assign w_accept = in_valid & in_ready;

    // Idle gating sits after the mux so the line rests at a known level.
    assign ser_out   = r_valid ? w_bit : IDLE_LEVEL;
    assign ser_valid = r_valid;
    assign ser_last  = r_last;
    assign sel       = r_sel;
    assign busy      = r_valid;

    // Serializer FSM: word capture, select stepping, reload or return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_word  <= 8'd0;
            r_sel   <= c_SEL_START;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_word  <= in_data;
                        r_sel   <= c_SEL_START;
                        r_state <= c_SHIFT;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                c_SHIFT: begin
                    if (ser_ready) begin
                        if (!w_sel_at_end) begin
                            r_sel <= w_sel_step;
`ifndef MUX_SERIALIZER_PARITY_EN
                            r_last <= w_step_at_end;
`endif
                        end else begin
`ifdef MUX_SERIALIZER_PARITY_EN
                            // sel parks at its end value for the parity bit.
                            r_state <= c_PARITY;
                            r_last  <= 1'b1;
`else
                            if (w_accept) begin
                                r_word <= in_data;
                                r_sel  <= c_SEL_START;
                                r_last <= 1'b0;
                            end else begin
                                r_state <= c_IDLE;
                                r_sel   <= c_SEL_START;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                            end
`endif
                        end
                    end
                end
`ifdef MUX_SERIALIZER_PARITY_EN
                c_PARITY: begin
                    if (ser_ready) begin
                        if (w_accept) begin
                            r_word  <= in_data;
                            r_sel   <= c_SEL_START;
                            r_state <= c_SHIFT;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= c_IDLE;
                            r_sel   <= c_SEL_START;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= c_IDLE;
                    r_sel   <= c_SEL_START;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_serializer_8b.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_serializer_8b
// Description : Scoreboard bench for mux_serializer_8b. Two instances (LSB-first
//               with idle level 0, MSB-first with idle level 1) share one
//               stimulus stream; accepted words are expanded into expected
//               bit records and a monitor pops them as bits transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_serializer_8b;

`ifdef MUX_SERIALIZER_PARITY_EN
    localparam int c_NB = 9;
`else
    localparam int c_NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       ser_ready;

    logic       in_ready_a, ser_valid_a, ser_out_a, ser_last_a, busy_a;
    logic [2:0] sel_a;
    logic       in_ready_b, ser_valid_b, ser_out_b, ser_last_b, busy_b;
    logic [2:0] sel_b;

    always #5 clk = ~clk;

    mux_serializer_8b #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .ser_ready(ser_ready), .ser_valid(ser_valid_a),
        .ser_out(ser_out_a), .ser_last(ser_last_a), .sel(sel_a), .busy(busy_a)
    );

    mux_serializer_8b #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .ser_ready(ser_ready), .ser_valid(ser_valid_b),
        .ser_out(ser_out_b), .ser_last(ser_last_b), .sel(sel_b), .busy(busy_b)
    );

    // One record per bit still owed: the word and the bit's position in it
    // (0..7 data, 8 parity).
    typedef struct {
        logic [7:0] word;
        int         idx;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_bit(input ent_t e, input bit lsb);
        if (e.idx == 8) return int'(^e.word);
        return lsb ? int'(e.word[e.idx]) : int'(e.word[7 - e.idx]);
    endfunction

    function automatic int exp_sel(input ent_t e, input bit lsb);
        if (e.idx == 8) return lsb ? 7 : 0;
        return lsb ? e.idx : 7 - e.idx;
    endfunction

    // One clock of stimulus: drive, check handshake outputs against the
    // number of owed bits, then record an accepted word.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit rs);
        bit exp_v;
        bit exp_r;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        ser_ready = r;
        rst       = rs;
        #2;
        exp_v = (q.size() != 0);
        exp_r = !exp_v || (q.size() == 1 && r);
        if (checking) begin
            chk("ser_valid_a", int'(ser_valid_a), int'(exp_v));
            chk("ser_valid_b", int'(ser_valid_b), int'(exp_v));
            chk("busy_a", int'(busy_a), int'(exp_v));
            chk("busy_b", int'(busy_b), int'(exp_v));
            chk("in_ready_a", int'(in_ready_a), int'(exp_r));
            chk("in_ready_b", int'(in_ready_b), int'(exp_r));
        end
        if (rs) begin
            q.delete();
        end else if (v && exp_r) begin
            for (int i = 0; i < c_NB; i++) begin
                ent_t e;
                e.word = d;
                e.idx  = i;
                q.push_back(e);
            end
        end
    endtask

    // Monitor: compare every presented bit with the oldest owed record.
    always @(negedge clk) begin
        ent_t e;
        if (checking && !rst) begin
            if (ser_valid_a) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_bit: got ser_valid=1 expected ser_valid=0 at %0t", $time);
                end else begin
                    e = q[0];
                    chk("bit_lsb", int'(ser_out_a), exp_bit(e, 1'b1));
                    chk("bit_msb", int'(ser_out_b), exp_bit(e, 1'b0));
                    chk("last_a", int'(ser_last_a), int'(e.idx == c_NB - 1));
                    chk("last_b", int'(ser_last_b), int'(e.idx == c_NB - 1));
                    chk("sel_a", int'(sel_a), exp_sel(e, 1'b1));
                    chk("sel_b", int'(sel_b), exp_sel(e, 1'b0));
                    if (ser_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_out_a", int'(ser_out_a), 0);
                chk("idle_out_b", int'(ser_out_b), 1);
                chk("idle_sel_a", int'(sel_a), 0);
                chk("idle_sel_b", int'(sel_b), 7);
                chk("idle_last_a", int'(ser_last_a), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        checking = 1'b1;

        // Single word, always-ready consumer.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h81, 1'b1, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Stalling consumer: ready pattern 1,0,0,1,0,0,...
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, (i % 3) == 0, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back: in_valid held; 8'h00 only lands in the last-bit slot.
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (c_NB) step(1'b1, 8'h00, 1'b1, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Abort mid-word, with a handshake offered during reset.
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h0F, 1'b1, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Parity-carrying word (plain 8 bits in the default build).
        step(1'b1, 8'h07, 1'b1, 1'b0);
        repeat (11) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 79) == 0);
        end

        repeat (14) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
